// File: rtl/jk_pkg.sv
// Shared types and JK excitation codes for the JK bank write controller.
package jk_pkg;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StDrive,
    StCheck,
    StErr
  } state_e;

  // {J,K} codes applied to one flip-flop.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Excitation needed to move one flip-flop from cur to nxt.
  function automatic logic [1:0] jk_code(input logic cur, input logic nxt,
                                         input logic use_toggle);
    logic [1:0] code;
    if (cur == nxt) begin
      code = JK_HOLD;
    end else if (use_toggle) begin
      code = JK_TOGGLE;
    end else begin
      code = nxt ? JK_SET : JK_RESET;
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: which {J,K} takes a flip-flop from cur to nxt.
module jk_excite
  import jk_pkg::*;
(
  input  logic cur,
  input  logic nxt,
  input  logic use_toggle,
  output logic j,
  output logic k
);

  // Pure lookup through the shared excitation function.
  always_comb begin
    {j, k} = jk_code(cur, nxt, use_toggle);
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Write-side controller for a bank of negedge JK flip-flops: accepts a target word, drives one
// cycle of J/K excitation against a shadow copy, then verifies the bank readback.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_rst_n,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  input  logic             clr_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d;
  logic [WIDTH-1:0] jk_k_q, jk_k_d;
  logic             jk_rst_n_q, jk_rst_n_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] exc_j, exc_k;

  // Excitation from the current shadow to the offered word, evaluated ahead of the accept edge
  // so J/K can be registered straight into the DRIVE cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    jk_excite u_exc (
      .cur       (shadow_q[i]),
      .nxt       (tgt_data[i]),
      .use_toggle(USE_TOGGLE),
      .j         (exc_j[i]),
      .k         (exc_k[i])
    );
  end

  // Next-state, datapath and registered bank controls.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    tgt_d      = tgt_q;
    jk_j_d     = '0;
    jk_k_d     = '0;
    jk_rst_n_d = 1'b1;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    unique case (state_q)
      StInit: begin
        shadow_d = '0;
        state_d  = StIdle;
      end
      StIdle: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          jk_j_d  = exc_j;
          jk_k_d  = exc_k;
          state_d = StDrive;
        end
      end
      StDrive: begin
        // The bank samples J/K mid-cycle; from here on it should hold the target.
        shadow_d = tgt_q;
        state_d  = StCheck;
      end
      StCheck: begin
        if (q_fb == shadow_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          mismatch_d = 1'b1;
          state_d    = StErr;
        end
      end
      StErr: begin
        if (clr_err) begin
          mismatch_d = 1'b0;
          jk_rst_n_d = 1'b0;
          state_d    = StInit;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State and output registers; reset parks the bank in clear with J/K idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      shadow_q   <= '0;
      tgt_q      <= '0;
      jk_j_q     <= '0;
      jk_k_q     <= '0;
      jk_rst_n_q <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      tgt_q      <= tgt_d;
      jk_j_q     <= jk_j_d;
      jk_k_q     <= jk_k_d;
      jk_rst_n_q <= jk_rst_n_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign tgt_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign jk_rst_n  = jk_rst_n_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;

endmodule
